// File: rtl/hazard_pkg.sv
// Shared types and default constants for the ARM pipeline hazard sequencer.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN,
    MEMWAIT
  } memfsm_t;

  localparam int unsigned INIT_FLUSH_DEF  = 2;
  localparam int unsigned MEM_TIMEOUT_DEF = 64;
  localparam int unsigned CNT_W_DEF       = 16;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Operand forwarding select: M-stage result wins over W-stage result.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic     match_m,
  input  logic     match_w,
  input  logic     reg_write_m,
  input  logic     reg_write_w,
  output fwd_sel_t sel
);

  always_comb begin
    sel = FWD_RF;
    if (match_m && reg_write_m)      sel = FWD_M;
    else if (match_w && reg_write_w) sel = FWD_W;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall sequencer with data-memory wait FSM and post-reset flush window.
// Optional performance counters enabled by defining HAZ_PERF_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned INIT_FLUSH  = INIT_FLUSH_DEF,
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
`ifdef HAZ_PERF_EN
  ,
  parameter int unsigned CNT_W       = CNT_W_DEF
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Match_1E_M,
  input  logic       Match_1E_W,
  input  logic       Match_2E_M,
  input  logic       Match_2E_W,
  input  logic       Match_12D_E,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       BranchTakenE,
  input  logic       PCWrPendingF,
  input  logic       PCSrcW,
  input  logic       MemAccessM,
  input  logic       MemReadyM,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic       MemFault
`ifdef HAZ_PERF_EN
  ,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic [CNT_W-1:0] MemWaitCnt
`endif
);

  localparam int unsigned IW = (INIT_FLUSH < 1) ? 1 : $clog2(INIT_FLUSH + 1);
  localparam int unsigned WW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [IW-1:0] INIT_VAL = IW'(INIT_FLUSH);
  localparam logic [WW-1:0] TO_VAL   = WW'(MEM_TIMEOUT);

  memfsm_t       state;
  logic [WW-1:0] waitCnt;
  logic [IW-1:0] initCnt;
  logic          memStall;
  logic          ldrStall;
  logic          initActive;

  fwd_sel u_fwd_a (
    .match_m     (Match_1E_M),
    .match_w     (Match_1E_W),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .sel         (ForwardAE)
  );

  fwd_sel u_fwd_b (
    .match_m     (Match_2E_M),
    .match_w     (Match_2E_W),
    .reg_write_m (RegWriteM),
    .reg_write_w (RegWriteW),
    .sel         (ForwardBE)
  );

  assign ldrStall   = Match_12D_E & MemtoRegE;
  assign initActive = (initCnt != '0);

  // The timeout cycle itself releases the stall so the pipeline can move on.
  always_comb begin
    memStall = 1'b0;
    case (state)
      RUN:     memStall = MemAccessM & ~MemReadyM;
      MEMWAIT: memStall = ~MemReadyM & (waitCnt != TO_VAL);
      default: memStall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      waitCnt  <= '0;
      initCnt  <= INIT_VAL;
      MemFault <= 1'b0;
    end else begin
      if (initActive) initCnt <= initCnt - 1'b1;
      case (state)
        RUN: begin
          if (MemAccessM && !MemReadyM) begin
            state   <= MEMWAIT;
            waitCnt <= WW'(1);
          end
        end
        MEMWAIT: begin
          if (MemReadyM) begin
            state <= RUN;
          end else if (waitCnt == TO_VAL) begin
            MemFault <= 1'b1;
            state    <= RUN;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Memory stall freezes everything upstream, so branch/load-use actions wait.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (memStall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (initActive) begin
      StallF = 1'b1;
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else begin
      StallF = ldrStall | PCWrPendingF;
      StallD = ldrStall;
      FlushD = PCWrPendingF | PCSrcW | BranchTakenE;
      FlushE = ldrStall | BranchTakenE;
    end
  end

`ifdef HAZ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCnt   <= '0;
      FlushCnt   <= '0;
      MemWaitCnt <= '0;
    end else begin
      if (StallF && (StallCnt != '1))               StallCnt   <= StallCnt + 1'b1;
      if ((FlushD || FlushE) && (FlushCnt != '1))   FlushCnt   <= FlushCnt + 1'b1;
      if (memStall && (MemWaitCnt != '1))           MemWaitCnt <= MemWaitCnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (MEM_TIMEOUT reduced to 4).
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
  logic RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, PCWrPendingF, PCSrcW;
  logic MemAccessM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemFault;
`ifdef HAZ_PERF_EN
  logic [15:0] StallCnt, FlushCnt, MemWaitCnt;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [11:0] exp;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.INIT_FLUSH(2), .MEM_TIMEOUT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .Match_1E_M   (Match_1E_M),
    .Match_1E_W   (Match_1E_W),
    .Match_2E_M   (Match_2E_M),
    .Match_2E_W   (Match_2E_W),
    .Match_12D_E  (Match_12D_E),
    .RegWriteM    (RegWriteM),
    .RegWriteW    (RegWriteW),
    .MemtoRegE    (MemtoRegE),
    .BranchTakenE (BranchTakenE),
    .PCWrPendingF (PCWrPendingF),
    .PCSrcW       (PCSrcW),
    .MemAccessM   (MemAccessM),
    .MemReadyM    (MemReadyM),
    .ForwardAE    (ForwardAE),
    .ForwardBE    (ForwardBE),
    .StallF       (StallF),
    .StallD       (StallD),
    .StallE       (StallE),
    .StallM       (StallM),
    .FlushD       (FlushD),
    .FlushE       (FlushE),
    .FlushW       (FlushW),
    .MemFault     (MemFault)
`ifdef HAZ_PERF_EN
    ,
    .StallCnt     (StallCnt),
    .FlushCnt     (FlushCnt),
    .MemWaitCnt   (MemWaitCnt)
`endif
  );

  // st = {StallF,StallD,StallE,StallM}, fl = {FlushD,FlushE,FlushW}
  function automatic logic [11:0] ex(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic [3:0] st, input logic [2:0] fl,
                                     input logic mf);
    return {fa, fb, st, fl, mf};
  endfunction

  task automatic step(input string tag, input logic [11:0] e);
    exp_t item;
    exp_t got;
    logic [11:0] obs;
    item.tag = tag;
    item.exp = e;
    sb.push_back(item);
    @(negedge clk);
    got = sb.pop_front();
    obs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemFault};
    total++;
    assert (obs === got.exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", got.tag, obs, got.exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    Match_1E_M = 0; Match_1E_W = 0; Match_2E_M = 0; Match_2E_W = 0; Match_12D_E = 0;
    RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; BranchTakenE = 0;
    PCWrPendingF = 0; PCSrcW = 0; MemAccessM = 0; MemReadyM = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

`ifdef HAZ_PERF_EN
    @(negedge clk);
    total++;
    assert ({StallCnt, FlushCnt, MemWaitCnt} === 48'd0) else begin
      bad++;
      $error("FAIL perf_rst observed=%h expected=0", {StallCnt, FlushCnt, MemWaitCnt});
    end
    @(posedge clk);
    #1;
    step("init1", ex(2'b00, 2'b00, 4'b1000, 3'b110, 1'b0));
`else
    step("init0", ex(2'b00, 2'b00, 4'b1000, 3'b110, 1'b0));
    step("init1", ex(2'b00, 2'b00, 4'b1000, 3'b110, 1'b0));
`endif
    step("idle", ex(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0));
`ifdef HAZ_PERF_EN
    total++;
    assert ({StallCnt, FlushCnt, MemWaitCnt} === {16'd2, 16'd2, 16'd0}) else begin
      bad++;
      $error("FAIL perf_init observed=%h expected=%h", {StallCnt, FlushCnt, MemWaitCnt},
             {16'd2, 16'd2, 16'd0});
    end
`endif

    // Forwarding priority
    Match_1E_M = 1; RegWriteM = 1; Match_1E_W = 1; RegWriteW = 1; Match_2E_W = 1;
    step("fwd_m", ex(2'b10, 2'b01, 4'b0000, 3'b000, 1'b0));
    RegWriteM = 0;
    step("fwd_w", ex(2'b01, 2'b01, 4'b0000, 3'b000, 1'b0));
    RegWriteW = 0;
    step("fwd_rf", ex(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0));
    clear_inputs();
    Match_2E_M = 1; RegWriteM = 1; Match_1E_W = 1; RegWriteW = 1;
    step("fwd_mix", ex(2'b01, 2'b10, 4'b0000, 3'b000, 1'b0));
    clear_inputs();

    // Load-use, PC-write and branch
    MemtoRegE = 1; Match_12D_E = 1;
    step("ldr", ex(2'b00, 2'b00, 4'b1100, 3'b010, 1'b0));
    clear_inputs();
    step("ldr_gone", ex(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0));
    PCWrPendingF = 1;
    step("pcpend", ex(2'b00, 2'b00, 4'b1000, 3'b100, 1'b0));
    clear_inputs();
    PCSrcW = 1;
    step("pcsrcw", ex(2'b00, 2'b00, 4'b0000, 3'b100, 1'b0));
    clear_inputs();
    BranchTakenE = 1;
    step("branch", ex(2'b00, 2'b00, 4'b0000, 3'b110, 1'b0));
    MemtoRegE = 1; Match_12D_E = 1;
    step("branch_ldr", ex(2'b00, 2'b00, 4'b1100, 3'b110, 1'b0));
    clear_inputs();

    // Memory wait: three low-ready cycles, then ready
    MemAccessM = 1; MemReadyM = 0;
    step("mw0", ex(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0));
    BranchTakenE = 1;
    step("mw1_defer", ex(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0));
    BranchTakenE = 0;
    step("mw2", ex(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0));
    MemReadyM = 1;
    step("mw_ready", ex(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0));
    step("zero_wait", ex(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0));
    clear_inputs();

    // Timeout with MEM_TIMEOUT = 4
    MemAccessM = 1; MemReadyM = 0;
    for (int i = 0; i < 4; i++)
      step($sformatf("to_stall%0d", i), ex(2'b00, 2'b00, 4'b1111, 3'b001, 1'b0));
    step("to_release", ex(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0));
    MemAccessM = 0;
    step("fault_set", ex(2'b00, 2'b00, 4'b0000, 3'b000, 1'b1));
    step("fault_sticky", ex(2'b00, 2'b00, 4'b0000, 3'b000, 1'b1));

    // Reset in the middle of a wait
    MemAccessM = 1;
    step("rw0", ex(2'b00, 2'b00, 4'b1111, 3'b001, 1'b1));
    step("rw1", ex(2'b00, 2'b00, 4'b1111, 3'b001, 1'b1));
    reset = 1;
    step("rw_rst", ex(2'b00, 2'b00, 4'b1111, 3'b001, 1'b1));
    reset = 0;
    MemAccessM = 0;
`ifdef HAZ_PERF_EN
    total++;
    assert ({StallCnt, FlushCnt, MemWaitCnt} === 48'd0) else begin
      bad++;
      $error("FAIL perf_rst2 observed=%h expected=0", {StallCnt, FlushCnt, MemWaitCnt});
    end
`endif
    step("rinit0", ex(2'b00, 2'b00, 4'b1000, 3'b110, 1'b0));
    step("rinit1", ex(2'b00, 2'b00, 4'b1000, 3'b110, 1'b0));
    step("ridle", ex(2'b00, 2'b00, 4'b0000, 3'b000, 1'b0));

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_left observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
